usb_rx_unstuff: RTL and testbench
=================================

# usb_rx_unstuff

Receive front end of the USB hub port: per-bit samples of the synchronized D+/D- pair are classified into line states, SYNC is located, NRZI is decoded, stuffed bits are removed, and EOP is detected. It sits directly upstream of the bit-serial-to-parallel deserializer. Its outputs are a qualified LSB-first bit stream plus a cancel strobe that flushes the deserializer on any receive error.

## Interface
- SYNC_LEN, 8: decoded SYNC length in bits; SYNC_LEN-1 zeros followed by a 1.
- STUFF_LIMIT, 6: number of consecutive 1s after which a stuffed 0 is mandatory.
- IDLE_STROBES, 7: consecutive J strobes required to leave ABORT.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- bit_stb  in  1  one-cycle strobe; dp/dm sampled only when high.
- dp  in  1  synchronized D+.
- dm  in  1  synchronized D-.
- rx_bit  out  1  decoded data bit.
- rx_bit_val  out  1  rx_bit qualifier; high exactly one cycle per emitted bit.
- rx_active  out  1  high from the cycle after SYNC completes until packet end or abort.
- rx_cancel  out  1  one-cycle pulse; flushes the downstream deserializer.
- rx_eop  out  1  one-cycle pulse on a clean end of packet.
- rx_err  out  1  one-cycle pulse on any sync, stuff, line or length error.

## Operation
- Line state on each strobe, per (dp,dm):
  - J = 10; K = 01; SE0 = 00; SE1 = 11.
- NRZI decoding:
  - Decoded bit = 1 when the line state equals prev_ls, 0 when it differs.
  - prev_ls updates on every J/K strobe.
  - prev_ls resets to J.
- IDLE:
  - K strobe -> SYNC, zero count = 1.
  - J/SE0 strobes ignored.
  - SE1 -> ABORT with rx_err.
- SYNC:
  - Decoded 0 -> zero count +1.
  - Decoded 1 with zero count == SYNC_LEN-1 -> DATA, ones_cnt = 1, bit_cnt = 0, rx_active set.
  - Decoded 1 with any other count -> rx_err, IDLE, prev_ls = current state.
  - More than SYNC_LEN-1 zeros -> rx_err, IDLE.
  - SE0 or SE1 -> rx_err, ABORT.
- DATA, per strobe:
  - SE0 -> EOP state.
  - SE1 -> error abort.
  - J/K with ones_cnt == STUFF_LIMIT:
    - Decoded 0: drop the bit, ones_cnt = 0.
    - Decoded 1: error abort.
  - J/K otherwise:
    - Emit the bit, bit_cnt = bit_cnt+1 (3-bit, wraps mod 8).
    - ones_cnt = bit ? ones_cnt+1 : 0; width clog2(STUFF_LIMIT+1).
- EOP:
  - Further SE0 strobes: stay.
  - J with bit_cnt == 0 -> rx_eop, IDLE.
  - J with bit_cnt != 0 -> rx_err + rx_cancel, IDLE.
  - K or SE1 -> error abort.
- Error abort, from any state:
  - rx_cancel and rx_err pulse together, rx_active drops, state -> ABORT.
- ABORT:
  - Count consecutive J strobes; K/SE0/SE1 resets the count to 0.
  - Count == IDLE_STROBES -> IDLE with prev_ls = J.
  - No pulses are issued from ABORT.
- rx_err never pulses twice for one packet.

## Timing
- All outputs are registered.
- A bit sampled on strobe cycle t appears as rx_bit/rx_bit_val at cycle t+1.
- bit_stb may be asserted every clk. Gaps in rx_bit_val occur only at non-strobe cycles and dropped stuff bits.
- rx_active:
  - Rises at t+1 after the final SYNC strobe.
  - Falls in the same cycle as the rx_eop or rx_cancel pulse.
- rx_eop / rx_cancel are asserted at t+1 after the terminating strobe. They never coincide with rx_bit_val.
- Reset values:
  - rx_bit, rx_bit_val, rx_active, rx_cancel, rx_eop, rx_err all 0.
  - State IDLE, prev_ls J, all counters 0.
- rst mid-packet: all outputs 0 on the next cycle; no rx_eop or rx_cancel pulse is generated.
- bit_stb low: no state change and no pulses.

## Structure
- Package usb_rx_pkg holds:
  - Line-state enum (LS_J, LS_K, LS_SE0, LS_SE1).
  - FSM state enum (IDLE, SYNC, DATA, EOP, ABORT).
  - Default constants for SYNC_LEN, STUFF_LIMIT, IDLE_STROBES.
- One sub-module, usb_nrzi_dec:
  - Line-state classification plus the prev_ls register.
  - Outputs ls and dec_bit, valid on bit_stb.
- The FSM, stuff counter, bit counter and output registers live in usb_rx_unstuff.

## Test plan
- Clean packet: SYNC KJKJKJKK then NRZI of 0xA5, SE0 SE0 J, strobe every clk -> bits 1,0,1,0,0,1,0,1 on rx_bit_val; one rx_eop; rx_err never high.
- Bit stuffing: payload 0xFF plus stuffed 0 -> exactly 8 emitted 1s, stuffed bit dropped, rx_eop; omit the stuffed 0 -> rx_cancel + rx_err on the 7th 1, then ABORT.
- Bad SYNC: KJKK then idle J -> rx_err once, no rx_active, return to IDLE; a following valid packet is received normally.
- Length error: SYNC + 5 data bits + SE0 SE0 J -> rx_cancel + rx_err, no rx_eop.
- Sparse strobes: bit_stb every 4th clk over the clean packet -> identical bit sequence; each rx_bit_val lands 1 clk after its strobe.
- rst asserted after 3 data bits -> all outputs 0 next cycle; the next valid packet decodes correctly.

Source files
------------

// File: rtl/usb_rx_pkg.sv
// rtl/usb_rx_pkg.sv - shared types and default constants for the USB receive front end
package usb_rx_pkg;

    typedef enum logic [1:0] {
        LS_J,
        LS_K,
        LS_SE0,
        LS_SE1
    } line_state_e;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        EOP,
        ABORT
    } rx_state_e;

    localparam int SYNC_LEN_DEF     = 8;
    localparam int STUFF_LIMIT_DEF  = 6;
    localparam int IDLE_STROBES_DEF = 7;

    // Map the synchronized (dp,dm) pair onto a line state.
    function automatic line_state_e classify(input logic dp, input logic dm);
        line_state_e ls;
        case ({dp, dm})
            2'b10:   ls = LS_J;
            2'b01:   ls = LS_K;
            2'b00:   ls = LS_SE0;
            default: ls = LS_SE1;
        endcase
        return ls;
    endfunction

endpackage

// File: rtl/usb_rx_if.sv
// rtl/usb_rx_if.sv - line-side inputs and decoded-stream outputs of the receive front end
interface usb_rx_if;

    logic bit_stb;
    logic dp;
    logic dm;
    logic rx_bit;
    logic rx_bit_val;
    logic rx_active;
    logic rx_cancel;
    logic rx_eop;
    logic rx_err;

    modport master (
        output bit_stb, dp, dm,
        input  rx_bit, rx_bit_val, rx_active, rx_cancel, rx_eop, rx_err
    );

    modport slave (
        input  bit_stb, dp, dm,
        output rx_bit, rx_bit_val, rx_active, rx_cancel, rx_eop, rx_err
    );

endinterface

// File: rtl/usb_nrzi_dec.sv
// rtl/usb_nrzi_dec.sv - line-state classification and NRZI decode against the last J/K level
module usb_nrzi_dec
    import usb_rx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        bit_stb,
    input  logic        dp,
    input  logic        dm,
    output line_state_e ls,
    output logic        dec_bit
);

    line_state_e prev_ls_q;
    line_state_e prev_ls_d;

    // Classify the sample; an unchanged J/K level decodes as 1, a transition as 0.
    always_comb begin
        ls        = classify(dp, dm);
        dec_bit   = (ls == prev_ls_q);
        prev_ls_d = prev_ls_q;
        if (bit_stb && (ls == LS_J || ls == LS_K)) begin
            prev_ls_d = ls;
        end
    end

    // Remember the last J/K level seen on a strobe; SE0/SE1 leave it untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_ls_q <= LS_J;
        end else begin
            prev_ls_q <= prev_ls_d;
        end
    end

endmodule

// File: rtl/usb_rx_unstuff.sv
// rtl/usb_rx_unstuff.sv - SYNC hunt, bit unstuffing, EOP detection and registered receive outputs
module usb_rx_unstuff
    import usb_rx_pkg::*;
#(
    parameter int SYNC_LEN     = SYNC_LEN_DEF,
    parameter int STUFF_LIMIT  = STUFF_LIMIT_DEF,
    parameter int IDLE_STROBES = IDLE_STROBES_DEF
) (
    input logic     clk,
    input logic     rst,
    usb_rx_if.slave bus
);

    localparam int ZC_W = $clog2(SYNC_LEN);
    localparam int OC_W = $clog2(STUFF_LIMIT + 1);
    localparam int IC_W = $clog2(IDLE_STROBES + 1);

    localparam logic [ZC_W-1:0] ZC_LAST  = ZC_W'(SYNC_LEN - 1);
    localparam logic [OC_W-1:0] OC_LIMIT = OC_W'(STUFF_LIMIT);
    localparam logic [IC_W-1:0] IC_LAST  = IC_W'(IDLE_STROBES - 1);

    line_state_e ls;
    logic        dec_bit;

    rx_state_e       state_q, state_d;
    logic [ZC_W-1:0] zero_cnt_q, zero_cnt_d;
    logic [OC_W-1:0] ones_cnt_q, ones_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [IC_W-1:0] idle_cnt_q, idle_cnt_d;
    logic            rx_bit_q, rx_bit_d;
    logic            rx_bit_val_q, rx_bit_val_d;
    logic            rx_active_q, rx_active_d;
    logic            rx_cancel_q, rx_cancel_d;
    logic            rx_eop_q, rx_eop_d;
    logic            rx_err_q, rx_err_d;
    logic            do_abort;

    usb_nrzi_dec u_nrzi (
        .clk     (clk),
        .rst     (rst),
        .bit_stb (bus.bit_stb),
        .dp      (bus.dp),
        .dm      (bus.dm),
        .ls      (ls),
        .dec_bit (dec_bit)
    );

    // Next-state and output decode; everything advances only on a bit strobe.
    always_comb begin
        state_d      = state_q;
        zero_cnt_d   = zero_cnt_q;
        ones_cnt_d   = ones_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        rx_bit_d     = rx_bit_q;
        rx_bit_val_d = 1'b0;
        rx_active_d  = rx_active_q;
        rx_cancel_d  = 1'b0;
        rx_eop_d     = 1'b0;
        rx_err_d     = 1'b0;
        do_abort     = 1'b0;

        if (bus.bit_stb) begin
            case (state_q)
                IDLE: begin
                    if (ls == LS_K) begin
                        state_d    = SYNC;
                        zero_cnt_d = ZC_W'(1);
                    end else if (ls == LS_SE1) begin
                        state_d    = ABORT;
                        idle_cnt_d = '0;
                        rx_err_d   = 1'b1;
                    end
                end
                SYNC: begin
                    if (ls == LS_J || ls == LS_K) begin
                        if (!dec_bit) begin
                            if (zero_cnt_q == ZC_LAST) begin
                                // SYNC ran longer than allowed
                                state_d    = IDLE;
                                zero_cnt_d = '0;
                                rx_err_d   = 1'b1;
                            end else begin
                                zero_cnt_d = zero_cnt_q + ZC_W'(1);
                            end
                        end else if (zero_cnt_q == ZC_LAST) begin
                            // SYNC's closing 1 already counts toward the stuffing run
                            state_d     = DATA;
                            zero_cnt_d  = '0;
                            ones_cnt_d  = OC_W'(1);
                            bit_cnt_d   = 3'd0;
                            rx_active_d = 1'b1;
                        end else begin
                            state_d    = IDLE;
                            zero_cnt_d = '0;
                            rx_err_d   = 1'b1;
                        end
                    end else begin
                        state_d    = ABORT;
                        zero_cnt_d = '0;
                        idle_cnt_d = '0;
                        rx_err_d   = 1'b1;
                    end
                end
                DATA: begin
                    if (ls == LS_SE0) begin
                        state_d = EOP;
                    end else if (ls == LS_SE1) begin
                        do_abort = 1'b1;
                    end else if (ones_cnt_q == OC_LIMIT) begin
                        if (!dec_bit) begin
                            ones_cnt_d = '0;
                        end else begin
                            do_abort = 1'b1;
                        end
                    end else begin
                        rx_bit_d     = dec_bit;
                        rx_bit_val_d = 1'b1;
                        bit_cnt_d    = bit_cnt_q + 3'd1;
                        ones_cnt_d   = dec_bit ? ones_cnt_q + OC_W'(1) : '0;
                    end
                end
                EOP: begin
                    if (ls == LS_J) begin
                        state_d     = IDLE;
                        rx_active_d = 1'b0;
                        if (bit_cnt_q == 3'd0) begin
                            rx_eop_d = 1'b1;
                        end else begin
                            rx_err_d    = 1'b1;
                            rx_cancel_d = 1'b1;
                        end
                    end else if (ls != LS_SE0) begin
                        do_abort = 1'b1;
                    end
                end
                ABORT: begin
                    if (ls == LS_J) begin
                        if (idle_cnt_q == IC_LAST) begin
                            state_d    = IDLE;
                            idle_cnt_d = '0;
                        end else begin
                            idle_cnt_d = idle_cnt_q + IC_W'(1);
                        end
                    end else begin
                        idle_cnt_d = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            if (do_abort) begin
                state_d     = ABORT;
                idle_cnt_d  = '0;
                rx_active_d = 1'b0;
                rx_cancel_d = 1'b1;
                rx_err_d    = 1'b1;
            end
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            zero_cnt_q   <= '0;
            ones_cnt_q   <= '0;
            bit_cnt_q    <= 3'd0;
            idle_cnt_q   <= '0;
            rx_bit_q     <= 1'b0;
            rx_bit_val_q <= 1'b0;
            rx_active_q  <= 1'b0;
            rx_cancel_q  <= 1'b0;
            rx_eop_q     <= 1'b0;
            rx_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            zero_cnt_q   <= zero_cnt_d;
            ones_cnt_q   <= ones_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_bit_val_q <= rx_bit_val_d;
            rx_active_q  <= rx_active_d;
            rx_cancel_q  <= rx_cancel_d;
            rx_eop_q     <= rx_eop_d;
            rx_err_q     <= rx_err_d;
        end
    end

    assign bus.rx_bit     = rx_bit_q;
    assign bus.rx_bit_val = rx_bit_val_q;
    assign bus.rx_active  = rx_active_q;
    assign bus.rx_cancel  = rx_cancel_q;
    assign bus.rx_eop     = rx_eop_q;
    assign bus.rx_err     = rx_err_q;

endmodule

// File: tb/tb_usb_rx_unstuff.sv
// tb/tb_usb_rx_unstuff.sv - self-checking bench for usb_rx_unstuff
module tb_usb_rx_unstuff;

    localparam logic [1:0] SJ  = 2'b10;
    localparam logic [1:0] SK  = 2'b01;
    localparam logic [1:0] S0  = 2'b00;

    logic clk = 1'b0;
    logic rst = 1'b1;
    usb_rx_if bus ();

    usb_rx_unstuff dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [1:0] sym_q[$];
    int exp_bits[$];
    int exp_eop, exp_err, exp_cancel;

    int got_bits[$];
    int n_eop, n_err, n_cancel, n_active, n_viol;
    logic prev_stb = 1'b0;

    // Observer: collects emitted bits and pulses, flags timing-rule violations.
    always @(negedge clk) begin
        if (bus.rx_bit_val) begin
            got_bits.push_back(int'(bus.rx_bit));
            if (!prev_stb) n_viol++;
            if (!bus.rx_active) n_viol++;
        end
        if (bus.rx_eop) n_eop++;
        if (bus.rx_err) n_err++;
        if (bus.rx_cancel) n_cancel++;
        if ((bus.rx_eop || bus.rx_cancel) && (bus.rx_bit_val || bus.rx_active)) n_viol++;
        if (bus.rx_active) n_active++;
        prev_stb = bus.bit_stb;
    end

    task automatic clear_mon();
        got_bits.delete();
        n_eop = 0; n_err = 0; n_cancel = 0; n_active = 0; n_viol = 0;
    endtask

    function automatic int bits_diff();
        int d;
        int n;
        d = (got_bits.size() > exp_bits.size()) ? got_bits.size() - exp_bits.size()
                                                 : exp_bits.size() - got_bits.size();
        n = (got_bits.size() < exp_bits.size()) ? got_bits.size() : exp_bits.size();
        for (int i = 0; i < n; i++) if (got_bits[i] != exp_bits[i]) d++;
        return d;
    endfunction

    // Reference model: NRZI-encode SYNC + stuffed payload and predict the outcome.
    // fault: when a stuffed 0 is due and the next payload bit is 1, send the 1 instead.
    task automatic build_packet(input int nbits, input logic [63:0] pay, input bit fault);
        logic [1:0] lvl;
        int ones;
        bit aborted;
        sym_q.delete();
        exp_bits.delete();
        lvl = SJ;
        aborted = 1'b0;
        for (int i = 0; i < 7; i++) begin
            lvl = (lvl == SJ) ? SK : SJ;
            sym_q.push_back(lvl);
        end
        sym_q.push_back(lvl);
        ones = 1;
        for (int i = 0; i < nbits && !aborted; i++) begin
            if (ones == 6) begin
                if (fault && pay[i]) begin
                    sym_q.push_back(lvl);
                    aborted = 1'b1;
                end else begin
                    lvl = (lvl == SJ) ? SK : SJ;
                    sym_q.push_back(lvl);
                    ones = 0;
                end
            end
            if (!aborted) begin
                if (pay[i]) begin
                    ones++;
                end else begin
                    ones = 0;
                    lvl = (lvl == SJ) ? SK : SJ;
                end
                sym_q.push_back(lvl);
                exp_bits.push_back(int'(pay[i]));
            end
        end
        if (aborted) begin
            sym_q.push_back(S0); sym_q.push_back(S0); sym_q.push_back(SK);
            exp_eop = 0; exp_err = 1; exp_cancel = 1;
        end else begin
            sym_q.push_back(S0); sym_q.push_back(S0); sym_q.push_back(SJ);
            exp_eop    = (nbits % 8 == 0) ? 1 : 0;
            exp_err    = 1 - exp_eop;
            exp_cancel = 1 - exp_eop;
        end
        repeat (8) sym_q.push_back(SJ);
    endtask

    task automatic send_syms(input int period, input int n_syms);
        for (int i = 0; i < n_syms; i++) begin
            @(posedge clk); #1;
            bus.bit_stb = 1'b1;
            {bus.dp, bus.dm} = sym_q[i];
            for (int k = 1; k < period; k++) begin
                @(posedge clk); #1;
                bus.bit_stb = 1'b0;
            end
        end
        @(posedge clk); #1;
        bus.bit_stb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.bit_stb = 1'b0;
        {bus.dp, bus.dm} = SJ;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.rx_bit !== 1'b0) begin failures++; $display("FAIL reset_rx_bit got=%b exp=0", bus.rx_bit); end
        checks++; if (bus.rx_bit_val !== 1'b0) begin failures++; $display("FAIL reset_rx_bit_val got=%b exp=0", bus.rx_bit_val); end
        checks++; if (bus.rx_active !== 1'b0) begin failures++; $display("FAIL reset_rx_active got=%b exp=0", bus.rx_active); end
        checks++; if (bus.rx_cancel !== 1'b0) begin failures++; $display("FAIL reset_rx_cancel got=%b exp=0", bus.rx_cancel); end
        checks++; if (bus.rx_eop !== 1'b0) begin failures++; $display("FAIL reset_rx_eop got=%b exp=0", bus.rx_eop); end
        checks++; if (bus.rx_err !== 1'b0) begin failures++; $display("FAIL reset_rx_err got=%b exp=0", bus.rx_err); end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_packet(input string name, input int nbits, input logic [63:0] pay,
                               input bit fault, input int period);
        build_packet(nbits, pay, fault);
        clear_mon();
        send_syms(period, sym_q.size());
        checks++; if (got_bits.size() != exp_bits.size()) begin failures++; $display("FAIL %s bit_count got=%0d exp=%0d", name, got_bits.size(), exp_bits.size()); end
        checks++; if (bits_diff() != 0) begin failures++; $display("FAIL %s bit_values diffs=%0d exp=0", name, bits_diff()); end
        checks++; if (n_eop != exp_eop) begin failures++; $display("FAIL %s rx_eop got=%0d exp=%0d", name, n_eop, exp_eop); end
        checks++; if (n_err != exp_err) begin failures++; $display("FAIL %s rx_err got=%0d exp=%0d", name, n_err, exp_err); end
        checks++; if (n_cancel != exp_cancel) begin failures++; $display("FAIL %s rx_cancel got=%0d exp=%0d", name, n_cancel, exp_cancel); end
        checks++; if (n_viol != 0) begin failures++; $display("FAIL %s timing_rules got=%0d exp=0", name, n_viol); end
    endtask

    task automatic test_clean();
        test_packet("clean_a5", 8, 64'hA5, 1'b0, 1);
    endtask

    task automatic test_stuffing();
        test_packet("stuff_ff", 8, 64'hFF, 1'b0, 1);
        test_packet("stuff_missing", 8, 64'hFF, 1'b1, 1);
        checks++; if (got_bits.size() != 5) begin failures++; $display("FAIL stuff_missing_emitted got=%0d exp=5", got_bits.size()); end
        test_packet("after_stuff_err", 16, 64'h3C5A, 1'b0, 1);
    endtask

    task automatic test_bad_sync();
        sym_q.delete();
        sym_q.push_back(SK); sym_q.push_back(SJ); sym_q.push_back(SK); sym_q.push_back(SK);
        repeat (8) sym_q.push_back(SJ);
        clear_mon();
        send_syms(1, sym_q.size());
        checks++; if (n_err != 1) begin failures++; $display("FAIL bad_sync rx_err got=%0d exp=1", n_err); end
        checks++; if (n_active != 0) begin failures++; $display("FAIL bad_sync rx_active_cycles got=%0d exp=0", n_active); end
        checks++; if (n_cancel + n_eop + got_bits.size() != 0) begin failures++; $display("FAIL bad_sync other_events got=%0d exp=0", n_cancel + n_eop + got_bits.size()); end
        test_packet("after_bad_sync", 8, 64'h5A, 1'b0, 1);
    endtask

    task automatic test_length_err();
        test_packet("length_5", 5, 64'h15, 1'b0, 1);
    endtask

    task automatic test_sparse();
        test_packet("sparse_a5", 8, 64'hA5, 1'b0, 4);
    endtask

    task automatic test_rst_mid();
        build_packet(8, 64'hA5, 1'b0);
        clear_mon();
        send_syms(1, 11);
        checks++; if (bus.rx_active !== 1'b1) begin failures++; $display("FAIL rst_mid active_before got=%b exp=1", bus.rx_active); end
        @(posedge clk); #1;
        rst = 1'b1;
        bus.bit_stb = 1'b0;
        {bus.dp, bus.dm} = SJ;
        @(posedge clk);
        @(negedge clk);
        checks++; if ({bus.rx_bit, bus.rx_bit_val, bus.rx_active, bus.rx_cancel, bus.rx_eop, bus.rx_err} !== 6'b0)
            begin failures++; $display("FAIL rst_mid outputs got=%b exp=000000",
                {bus.rx_bit, bus.rx_bit_val, bus.rx_active, bus.rx_cancel, bus.rx_eop, bus.rx_err}); end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (got_bits.size() != 3) begin failures++; $display("FAIL rst_mid bits_before got=%0d exp=3", got_bits.size()); end
        checks++; if (n_eop + n_cancel + n_err != 0) begin failures++; $display("FAIL rst_mid pulses got=%0d exp=0", n_eop + n_cancel + n_err); end
        test_packet("after_rst", 8, 64'hA5, 1'b0, 1);
    endtask

    task automatic test_random();
        logic [63:0] pay;
        int nbits;
        for (int it = 0; it < 20; it++) begin
            nbits = $urandom_range(1, 40);
            pay = '0;
            for (int i = 0; i < nbits; i++) pay[i] = ($urandom_range(0, 3) != 0);
            test_packet($sformatf("random_%0d", it), nbits, pay,
                        ($urandom_range(0, 2) == 0), $urandom_range(1, 3));
        end
    endtask

    initial begin
        bus.bit_stb = 1'b0;
        bus.dp = 1'b1;
        bus.dm = 1'b0;
        clear_mon();
        test_reset();
        test_clean();
        test_stuffing();
        test_bad_sync();
        test_length_err();
        test_sparse();
        test_rst_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
